mem_port_arbiter: RTL

Two-requester arbiter that shares one unified single-port memory between the processor's instruction fetch path and its load/store data path. It sits between the program counter / instruction-fetch logic, the ALU-addressed data access, and a variable-latency memory with a req/ack handshake. While either path is waiting, it raises a stall so the PC and register-file write-back hold.

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, variable-latency memory between the instruction
//   fetch path and the load/store data path. Data wins simultaneous requests
//   unless the previous grant was also data, so neither side waits more than
//   one access. Every access walks IDLE -> BUSY_x -> RESP.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   : 8-bit ack watchdog. After TIMEOUT busy cycles without memAck
//               the access is ended with data 32'hDEADBEEF and busErr sets
//               (sticky until nRST).
//   undefined : BUSY_x waits for memAck indefinitely; busErr is tied low.
//
// Ports
//   sysCLK, nRST           clock (rising edge), async active-low reset
//   ifReq/ifAddr           fetch request (held until ifValid) and address
//   ifData/ifValid         registered fetch data, one-cycle completion pulse
//   dReq/dWe/dAddr/dWData  data request (held until dValid), store flag, addr, data
//   dRData/dValid          registered load data, one-cycle completion pulse
//   memReq/memWe/memAddr/memWData  registered memory request side
//   memRData/memAck        memory read data, single-cycle completion
//   stall                  pipeline hold while either requester waits
//   busErr                 sticky watchdog error
module mem_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              sysCLK,
   input  logic              nRST,
   input  logic              ifReq,
   input  logic [ADDR_W-1:0] ifAddr,
   output logic [DATA_W-1:0] ifData,
   output logic              ifValid,
   input  logic              dReq,
   input  logic              dWe,
   input  logic [ADDR_W-1:0] dAddr,
   input  logic [DATA_W-1:0] dWData,
   output logic [DATA_W-1:0] dRData,
   output logic              dValid,
   output logic              memReq,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWData,
   input  logic [DATA_W-1:0] memRData,
   input  logic              memAck,
   output logic              stall,
   output logic              busErr
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

   localparam logic [DATA_W-1:0] BAD_DATA = DATA_W'(32'hDEADBEEF);

   state_t state, state_nxt;
   logic   last_was_d;
   logic   grant_i, grant_d;
   logic   capture, expire;
   logic   busy;
   logic   wd_expire;

   assign busy  = (state == BUSY_I) || (state == BUSY_D);
   assign stall = (ifReq & ~ifValid) | (dReq & ~dValid);

   always_ff @(posedge sysCLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      capture   = 1'b0;
      expire    = 1'b0;
      case (state)
         IDLE: begin
            if (dReq && (!last_was_d || !ifReq)) begin
               grant_d   = 1'b1;
               state_nxt = BUSY_D;
            end else if (ifReq) begin
               grant_i   = 1'b1;
               state_nxt = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            // A real ack always beats the watchdog in the same cycle.
            if (memAck) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end else if (wd_expire) begin
               expire    = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Memory-side registers and response capture. The valids are set on the
   // capture edge so they are high exactly during RESP.
   always_ff @(posedge sysCLK or negedge nRST) begin
      if (!nRST) begin
         last_was_d <= 1'b0;
         memReq     <= 1'b0;
         memWe      <= 1'b0;
         memAddr    <= '0;
         memWData   <= '0;
         ifData     <= '0;
         dRData     <= '0;
         ifValid    <= 1'b0;
         dValid     <= 1'b0;
      end else begin
         ifValid <= 1'b0;
         dValid  <= 1'b0;
         if (grant_i || grant_d) begin
            memReq     <= 1'b1;
            memWe      <= grant_d & dWe;
            memAddr    <= grant_d ? dAddr : ifAddr;
            last_was_d <= grant_d;
            if (grant_d) memWData <= dWData;
         end
         if (capture || expire) begin
            memReq <= 1'b0;
            memWe  <= 1'b0;
            if (state == BUSY_I) begin
               ifData  <= capture ? memRData : BAD_DATA;
               ifValid <= 1'b1;
            end else begin
               if (!memWe) dRData <= capture ? memRData : BAD_DATA;
               dValid <= 1'b1;
            end
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   logic [7:0] wd_cnt;

   // Counter value k means k busy cycles have passed without an ack, so
   // matching TIMEOUT-1 ends the access after exactly TIMEOUT busy cycles.
   assign wd_expire = busy && (wd_cnt == WD_LAST);

   always_ff @(posedge sysCLK or negedge nRST) begin
      if (!nRST) begin
         wd_cnt <= '0;
         busErr <= 1'b0;
      end else begin
         if (grant_i || grant_d)  wd_cnt <= '0;
         else if (busy && !memAck) wd_cnt <= wd_cnt + 8'd1;
         if (expire) busErr <= 1'b1;
      end
   end
`else
   // TIMEOUT has no effect without the watchdog.
   localparam int unused_timeout = TIMEOUT;

   assign wd_expire = 1'b0;
   assign busErr    = 1'b0;
`endif

endmodule
